// File: rtl/array_9_pkg.sv
// Shared types and constants for the array_9 RAM arbiter.
package array_9_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnA,
        OwnB
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wmode;
        logic [DATA_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/array_9_arb_if.sv
// Request/response ports A and B, the RW0 RAM port and init status of array_9_arb.
interface array_9_arb_if;
    import array_9_pkg::*;

    logic              a_req_valid;
    logic              a_req_ready;
    logic [ADDR_W-1:0] a_req_addr;
    logic              a_req_wmode;
    logic [DATA_W-1:0] a_req_wmask;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_resp_valid;
    logic [DATA_W-1:0] a_resp_rdata;

    logic              b_req_valid;
    logic              b_req_ready;
    logic [ADDR_W-1:0] b_req_addr;
    logic              b_req_wmode;
    logic [DATA_W-1:0] b_req_wmask;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_resp_valid;
    logic [DATA_W-1:0] b_resp_rdata;

    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [DATA_W-1:0] RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    logic              init_done;

    // Arbiter side.
    modport slave (
        input  a_req_valid, a_req_addr, a_req_wmode, a_req_wmask, a_req_wdata,
        output a_req_ready, a_resp_valid, a_resp_rdata,
        input  b_req_valid, b_req_addr, b_req_wmode, b_req_wmask, b_req_wdata,
        output b_req_ready, b_resp_valid, b_resp_rdata,
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata,
        output init_done
    );

    // Requester and RAM side.
    modport master (
        output a_req_valid, a_req_addr, a_req_wmode, a_req_wmask, a_req_wdata,
        input  a_req_ready, a_resp_valid, a_resp_rdata,
        output b_req_valid, b_req_addr, b_req_wmode, b_req_wmask, b_req_wdata,
        input  b_req_ready, b_resp_valid, b_resp_rdata,
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata,
        input  init_done
    );

endinterface

// File: rtl/array_9_rr2.sv
// Two-way round-robin arbiter: bit 0 = port A, bit 1 = port B, one-hot grant.
module array_9_rr2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prefer_b_q;
    logic prefer_b_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prefer_b_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After a grant the other port wins the next tie; idle cycles keep the pointer.
    always_comb begin
        prefer_b_d = prefer_b_q;
        if (grant != 2'b00) begin
            prefer_b_d = grant[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prefer_b_q <= 1'b0;
        end else begin
            prefer_b_q <= prefer_b_d;
        end
    end

endmodule

// File: rtl/array_9_arb.sv
// Round-robin arbiter/sequencer for the array_9 RW0 port, with 1-cycle read return.
// Define ARRAY_9_ARB_INIT_EN to zero-fill the array after reset before accepting traffic.
module array_9_arb
    import array_9_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    array_9_arb_if.slave  bus
);

    state_e     state_q;
    owner_e     owner_q;
    owner_e     owner_d;
    logic       run;
    logic       arb_en;
    logic [1:0] grant;
    req_t       a_req;
    req_t       b_req;
    req_t       sel_req;

`ifdef ARRAY_9_ARB_INIT_EN
    state_e            state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic [ADDR_W-1:0] init_cnt_d;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end
`else
    assign state_q = StRun;
`endif

    assign run    = (state_q == StRun);
    // Keeps ready low while reset is held, even in a build without the init sweep.
    assign arb_en = run & ~reset;

    assign a_req = {bus.a_req_addr, bus.a_req_wmode, bus.a_req_wmask, bus.a_req_wdata};
    assign b_req = {bus.b_req_addr, bus.b_req_wmode, bus.b_req_wmask, bus.b_req_wdata};

    array_9_rr2 u_rr2 (
        .clock  (clock),
        .reset  (reset),
        .enable (arb_en),
        .valid  ({bus.b_req_valid, bus.a_req_valid}),
        .grant  (grant)
    );

    assign sel_req = grant[1] ? b_req : a_req;

    always_comb begin
        bus.RW0_en    = |grant;
        bus.RW0_addr  = sel_req.addr;
        bus.RW0_wmode = sel_req.wmode;
        bus.RW0_wmask = sel_req.wmask;
        bus.RW0_wdata = sel_req.wdata;
`ifdef ARRAY_9_ARB_INIT_EN
        if (state_q == StInit) begin
            bus.RW0_en    = 1'b1;
            bus.RW0_addr  = init_cnt_q;
            bus.RW0_wmode = 1'b1;
            bus.RW0_wmask = '1;
            bus.RW0_wdata = '0;
        end
`endif
    end

    always_comb begin
        owner_d = OwnNone;
        if (grant[0] && !a_req.wmode) begin
            owner_d = OwnA;
        end else if (grant[1] && !b_req.wmode) begin
            owner_d = OwnB;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign bus.a_req_ready  = grant[0];
    assign bus.b_req_ready  = grant[1];
    assign bus.a_resp_valid = (owner_q == OwnA);
    assign bus.b_resp_valid = (owner_q == OwnB);
    assign bus.a_resp_rdata = bus.RW0_rdata;
    assign bus.b_resp_rdata = bus.RW0_rdata;
    assign bus.init_done    = run;

endmodule

// File: tb/tb_array_9_arb.sv
// Scoreboard bench for array_9_arb with a bit-masked synchronous-read RAM model on RW0.
module tb_array_9_arb;
    import array_9_pkg::*;

    typedef struct {
        owner_e            port;
        logic [DATA_W-1:0] data;
    } exp_t;

    localparam req_t NO_REQ = '0;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    array_9_arb_if bus ();

    array_9_arb dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] ram [DEPTH];

    always @(posedge clock) begin
        if (bus.RW0_en) begin
            if (bus.RW0_wmode) begin
                ram[bus.RW0_addr] <= (ram[bus.RW0_addr] & ~bus.RW0_wmask)
                                   | (bus.RW0_wdata & bus.RW0_wmask);
            end else begin
                bus.RW0_rdata <= ram[bus.RW0_addr];
            end
        end
    end

    logic [DATA_W-1:0] shadow [DEPTH];
    exp_t              sb_q [$];
    owner_e            last_grant;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, want);
        end
    endtask

    function automatic req_t mk(input int addr, input bit wmode, input int mask, input int data);
        req_t r;
        r.addr  = ADDR_W'(addr);
        r.wmode = wmode;
        r.wmask = DATA_W'(mask);
        r.wdata = DATA_W'(data);
        return r;
    endfunction

    task automatic check_resp();
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("a_resp_valid", bus.a_resp_valid, e.port == OwnA);
            check_eq("b_resp_valid", bus.b_resp_valid, e.port == OwnB);
            if (e.port == OwnA) check_eq("a_resp_rdata", bus.a_resp_rdata, e.data);
            else                check_eq("b_resp_rdata", bus.b_resp_rdata, e.data);
        end else begin
            check_eq("a_resp_idle", bus.a_resp_valid, 0);
            check_eq("b_resp_idle", bus.b_resp_valid, 0);
        end
    endtask

    // One clock: check last cycle's response, drive requests, account for the handshake.
    task automatic cycle(input logic av, input req_t ar, input logic bv, input req_t br);
        req_t r;
        @(negedge clock);
        check_resp();
        check_eq("init_done", bus.init_done, 1);
        bus.a_req_valid = av;
        {bus.a_req_addr, bus.a_req_wmode, bus.a_req_wmask, bus.a_req_wdata} = ar;
        bus.b_req_valid = bv;
        {bus.b_req_addr, bus.b_req_wmode, bus.b_req_wmask, bus.b_req_wdata} = br;
        #1;
        check_eq("single_grant", bus.a_req_ready & bus.b_req_ready, 0);
        last_grant = OwnNone;
        r = NO_REQ;
        if (av && bus.a_req_ready) begin
            last_grant = OwnA;
            r = ar;
        end else if (bv && bus.b_req_ready) begin
            last_grant = OwnB;
            r = br;
        end
        if (last_grant != OwnNone) begin
            check_eq("rw0_en", bus.RW0_en, 1);
            check_eq("rw0_addr", bus.RW0_addr, r.addr);
            check_eq("rw0_wmode", bus.RW0_wmode, r.wmode);
            if (r.wmode) begin
                check_eq("rw0_wmask", bus.RW0_wmask, r.wmask);
                check_eq("rw0_wdata", bus.RW0_wdata, r.wdata);
                shadow[r.addr] = (shadow[r.addr] & ~r.wmask) | (r.wdata & r.wmask);
            end else begin
                sb_q.push_back('{port: last_grant, data: shadow[r.addr]});
            end
        end else begin
            if (av || bv) check_eq("lost_grant", 1, 0);
            check_eq("idle_en", bus.RW0_en, 0);
        end
    endtask

`ifdef ARRAY_9_ARB_INIT_EN
    // Entered at the negedge where reset was released; port A holds valid throughout.
    task automatic init_sweep();
        bus.a_req_valid = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i > 0) @(negedge clock);
            #1;
            check_eq("init_en", bus.RW0_en, 1);
            check_eq("init_wmode", bus.RW0_wmode, 1);
            check_eq("init_addr", bus.RW0_addr, i);
            check_eq("init_wdata", bus.RW0_wdata, 0);
            check_eq("init_wmask", bus.RW0_wmask, 4'hF);
            check_eq("init_ready", bus.a_req_ready, 0);
            check_eq("init_done_low", bus.init_done, 0);
        end
        bus.a_req_valid = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
    endtask
`endif

    initial begin
        bus.a_req_valid = 1'b1;
        bus.b_req_valid = 1'b1;
        {bus.a_req_addr, bus.a_req_wmode, bus.a_req_wmask, bus.a_req_wdata} = NO_REQ;
        {bus.b_req_addr, bus.b_req_wmode, bus.b_req_wmask, bus.b_req_wdata} = NO_REQ;
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_a_ready", bus.a_req_ready, 0);
        check_eq("rst_b_ready", bus.b_req_ready, 0);
        check_eq("rst_a_resp", bus.a_resp_valid, 0);
        check_eq("rst_b_resp", bus.b_resp_valid, 0);
        bus.b_req_valid = 1'b0;
`ifdef ARRAY_9_ARB_INIT_EN
        check_eq("rst_init_done", bus.init_done, 0);
        @(negedge clock);
        reset = 1'b0;
        init_sweep();
        cycle(1, mk(7, 0, 0, 0), 0, NO_REQ);
`else
        check_eq("rst_init_done", bus.init_done, 1);
        bus.a_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
`endif
        // Single port write then read.
        cycle(1, mk(3, 1, 4'hF, 4'hA), 0, NO_REQ);
        cycle(1, mk(3, 0, 0, 0), 0, NO_REQ);
        cycle(0, NO_REQ, 0, NO_REQ);
        // Partial mask write.
        cycle(1, mk(5, 1, 4'hF, 4'hF), 0, NO_REQ);
        cycle(0, NO_REQ, 1, mk(5, 1, 4'b0101, 4'h0));
        cycle(0, NO_REQ, 1, mk(5, 0, 0, 0));
        // Fairness: last grant was B, so the first tie goes to A.
        for (int k = 0; k < 6; k++) begin
            cycle(1, mk(3, 0, 0, 0), 1, mk(5, 0, 0, 0));
            check_eq("fair_grant", last_grant, (k % 2 == 0) ? OwnA : OwnB);
        end
        // Read-after-write on consecutive grants.
        cycle(1, mk(31, 1, 4'hF, 4'h6), 0, NO_REQ);
        cycle(0, NO_REQ, 1, mk(31, 0, 0, 0));
        cycle(0, NO_REQ, 0, NO_REQ);
        // Reset between a read grant and its return edge drops the response.
        cycle(1, mk(3, 0, 0, 0), 0, NO_REQ);
        check_eq("rst_mid_grant", last_grant, OwnA);
        reset = 1'b1;
        bus.a_req_valid = 1'b0;
        sb_q.delete();
        @(negedge clock);
        check_eq("rst_mid_a_resp", bus.a_resp_valid, 0);
        check_eq("rst_mid_b_resp", bus.b_resp_valid, 0);
        reset = 1'b0;
`ifdef ARRAY_9_ARB_INIT_EN
        init_sweep();
`endif
        // Pointer back to A-preferred after reset.
        cycle(1, mk(3, 0, 0, 0), 1, mk(31, 0, 0, 0));
        check_eq("post_rst_tie", last_grant, OwnA);
        cycle(1, mk(3, 0, 0, 0), 1, mk(31, 0, 0, 0));
        check_eq("post_rst_tie2", last_grant, OwnB);
        cycle(0, NO_REQ, 0, NO_REQ);
        cycle(0, NO_REQ, 0, NO_REQ);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
